// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and pulse-convert three push-buttons.
// Define BUTTON_REPEAT_EN to add hold-to-repeat pulses on the value channel.
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ButtonModeRaw,
    input  logic       ButtonDigitRaw,
    input  logic       ButtonValueRaw,
    output logic       ButtonMode,
    output logic       ButtonDigit,
    output logic       ButtonValue,
    output logic [2:0] Held
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]             raw, s;
    logic [SYNC_STAGES-1:0] sync_q [3], sync_d [3];
    state_t                 state_q [3], state_d [3];
    logic [CW-1:0]          cnt_q [3], cnt_d [3];
    logic [2:0]             pulse_q, pulse_d, held_q, held_d;

`ifdef BUTTON_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rpt_q, rpt_d;
    logic          first_q, first_d;
`endif

    assign raw = {ButtonValueRaw, ButtonDigitRaw, ButtonModeRaw};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            s[i]       = sync_q[i][SYNC_STAGES-1];
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pulse_d[i] = 1'b0;
            held_d[i]  = held_q[i];
            case (state_q[i])
                IDLE: if (s[i]) begin
                    state_d[i] = PRESS_WAIT;
                    cnt_d[i]   = CW'(1);
                end
                PRESS_WAIT: if (!s[i]) begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end else if (cnt_q[i] == TERM) begin
                    state_d[i] = PRESSED;
                    cnt_d[i]   = '0;
                    pulse_d[i] = 1'b1;
                    held_d[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
                PRESSED: if (!s[i]) begin
                    state_d[i] = RELEASE_WAIT;
                    cnt_d[i]   = CW'(1);
                end
                RELEASE_WAIT: if (s[i]) begin
                    state_d[i] = PRESSED;
                    cnt_d[i]   = '0;
                end else if (cnt_q[i] == TERM) begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                    held_d[i]  = 1'b0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
                default: state_d[i] = IDLE;
            endcase
        end
`ifdef BUTTON_REPEAT_EN
        // counter restarts after each repeat; first_q selects delay vs period target
        rpt_d   = rpt_q;
        first_d = first_q;
        if (state_q[2] == PRESSED) begin
            if (int'(rpt_q) == (first_q ? REPEAT_PERIOD : REPEAT_DELAY) - 1) begin
                pulse_d[2] = 1'b1;
                rpt_d      = '0;
                first_d    = 1'b1;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end else if (state_q[2] == IDLE) begin
            rpt_d   = '0;
            first_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pulse_q <= '0;
            held_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
`ifdef BUTTON_REPEAT_EN
            rpt_q   <= '0;
            first_q <= 1'b0;
`endif
        end else begin
            pulse_q <= pulse_d;
            held_q  <= held_d;
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef BUTTON_REPEAT_EN
            rpt_q   <= rpt_d;
            first_q <= first_d;
`endif
        end
    end

    assign ButtonMode  = pulse_q[0];
    assign ButtonDigit = pulse_q[1];
    assign ButtonValue = pulse_q[2];
    assign Held        = held_q;
endmodule
